mem_stage: RTL and testbench

Memory stage of the 16-bit pipelined CPU, directly downstream of the ALU. It takes each executed instruction from EX, with the ALU result used as the data address for LW/SW and as the writeback value otherwise. It runs a request/done handshake with the data memory, stalls EX while an access is outstanding, and presents one registered writeback record per instruction to WB.

---
 rtl/mem_stage_if.sv | 60 ++++++
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bus bundles around the memory stage: EX->MEM issue, MEM<->data memory, MEM->WB record.
`default_nettype none

interface mem_ex_if #(
   parameter int DATA_W = 16
);
   logic              ex_valid;
   logic              ex_ready;
   logic [3:0]        ex_opcode;
   logic [DATA_W-1:0] ex_alu_out;
   logic [DATA_W-1:0] ex_st_data;
   logic [3:0]        ex_rd;

   modport master (
      output ex_valid, ex_opcode, ex_alu_out, ex_st_data, ex_rd,
      input  ex_ready
   );
   modport slave (
      input  ex_valid, ex_opcode, ex_alu_out, ex_st_data, ex_rd,
      output ex_ready
   );
endinterface

interface mem_dmem_if #(
   parameter int DATA_W = 16
);
   logic              mem_en;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;

   modport master (
      output mem_en, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_done
   );
   modport slave (
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_done
   );
endinterface

interface mem_wb_if #(
   parameter int DATA_W = 16
);
   logic              wb_valid;
   logic              wb_we;
   logic [3:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output wb_valid, wb_we, wb_rd, wb_data
   );
   modport slave (
      input  wb_valid, wb_we, wb_rd, wb_data
   );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: 16-bit CPU memory stage; issues LW/SW to data memory with a
// request/done handshake, stalls EX meanwhile, emits one registered WB record per instruction.
`default_nettype none

module mem_stage #(
   parameter int DATA_W      = 16,
   parameter int STALL_CNT_W = 16
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   mem_ex_if.slave                     ex,
   mem_dmem_if.master                  dmem,
   mem_wb_if.master                    wb,
   output logic                        align_err,
   output logic                        halted,
   output logic [STALL_CNT_W-1:0]      stall_cycles
);

   localparam logic [3:0] c_OP_LW  = 4'b1000;
   localparam logic [3:0] c_OP_SW  = 4'b1001;
   localparam logic [3:0] c_OP_HLT = 4'b1111;
   localparam logic [STALL_CNT_W-1:0] c_STALL_MAX = {STALL_CNT_W{1'b1}};
   localparam logic [STALL_CNT_W-1:0] c_STALL_ONE = STALL_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_HALTED   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic              w_accept;
   logic              w_done;
   logic              w_ex_ready;
   logic              w_mem_en;
   logic              w_is_mem;
   logic              w_is_pass;
   logic              w_is_hlt;

   logic              r_mem_wr;
   logic [DATA_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [3:0]        r_rd;
   logic              r_wb_valid;
   logic              r_wb_we;
   logic [3:0]        r_wb_rd;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_align_err;
   logic              r_halted;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   // Opcode classification; anything not pass-through, memory or HLT is a branch.
   always_comb begin
      w_is_mem  = 1'b0;
      w_is_pass = 1'b0;
      w_is_hlt  = 1'b0;
      case (ex.ex_opcode)
         4'b0000, 4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0101, 4'b0110, 4'b0111,
         4'b1010, 4'b1011, 4'b1110:  w_is_pass = 1'b1;
         c_OP_LW, c_OP_SW:           w_is_mem  = 1'b1;
         c_OP_HLT:                   w_is_hlt  = 1'b1;
         default:                    w_is_pass = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ex_ready  = 1'b0;
      w_mem_en    = 1'b0;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ex_ready = 1'b1;
            w_accept   = ex.ex_valid;
            if (ex.ex_valid) begin
               if (w_is_mem) begin
                  w_state_nxt = S_MEM_WAIT;
               end else if (w_is_hlt) begin
                  w_state_nxt = S_HALTED;
               end
            end
         end
         S_MEM_WAIT: begin
            w_mem_en = 1'b1;
            w_done   = dmem.mem_done;
            if (dmem.mem_done) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_HALTED: begin
            w_state_nxt = S_HALTED;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rd        <= 4'd0;
         r_wb_valid  <= 1'b0;
         r_wb_we     <= 1'b0;
         r_wb_rd     <= 4'd0;
         r_wb_data   <= '0;
         r_align_err <= 1'b0;
         r_halted    <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_wb_valid <= 1'b0;
         if (w_accept) begin
            if (w_is_mem) begin
               // Misaligned accesses still go out, at the word-aligned address.
               r_mem_addr  <= {ex.ex_alu_out[DATA_W-1:1], 1'b0};
               r_mem_wdata <= ex.ex_st_data;
               r_mem_wr    <= (ex.ex_opcode == c_OP_SW);
               r_rd        <= ex.ex_rd;
               if (ex.ex_alu_out[0]) begin
                  r_align_err <= 1'b1;
               end
            end else begin
               r_wb_valid <= 1'b1;
               r_wb_rd    <= ex.ex_rd;
               r_wb_we    <= w_is_pass;
               r_wb_data  <= w_is_pass ? ex.ex_alu_out : '0;
               if (w_is_hlt) begin
                  r_halted <= 1'b1;
               end
            end
         end
         if (w_mem_en && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_STALL_ONE;
         end
         if (w_done) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_we    <= ~r_mem_wr;
            r_wb_data  <= r_mem_wr ? '0 : dmem.mem_rdata;
         end
      end
   end

   assign ex.ex_ready    = w_ex_ready;
   assign dmem.mem_en    = w_mem_en;
   assign dmem.mem_wr    = r_mem_wr;
   assign dmem.mem_addr  = r_mem_addr;
   assign dmem.mem_wdata = r_mem_wdata;
   assign wb.wb_valid    = r_wb_valid;
   assign wb.wb_we       = r_wb_we;
   assign wb.wb_rd       = r_wb_rd;
   assign wb.wb_data     = r_wb_data;
   assign align_err      = r_align_err;
   assign halted         = r_halted;
   assign stall_cycles   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ops plus hand-written memory,
// reset, halt and counter-saturation sequences.
`default_nettype none

module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic        align_err;
   logic        halted;
   logic [15:0] stall_cycles;

   int checks;
   int failures;

   mem_ex_if   #(.DATA_W(16)) ex_bus ();
   mem_dmem_if #(.DATA_W(16)) dm_bus ();
   mem_wb_if   #(.DATA_W(16)) wb_bus ();

   mem_stage #(.DATA_W(16), .STALL_CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex           (ex_bus),
      .dmem         (dm_bus),
      .wb           (wb_bus),
      .align_err    (align_err),
      .halted       (halted),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] alu;
      logic [3:0]  rd;
      logic        we;
      logic [15:0] data;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu,
                        input logic [15:0] sd, input logic [3:0] rd);
      ex_bus.ex_valid   = v;
      ex_bus.ex_opcode  = op;
      ex_bus.ex_alu_out = alu;
      ex_bus.ex_st_data = sd;
      ex_bus.ex_rd      = rd;
   endtask

   // Issue a LW/SW at the current negedge; memory answers in the lat-th mem_en cycle.
   task automatic mem_op(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] sd,
                         input logic [3:0] rd, input int lat, input logic [15:0] rdata);
      logic [15:0] exp_addr;
      logic        is_wr;
      exp_addr = {addr[15:1], 1'b0};
      is_wr    = (op == 4'b1001);
      drive(1'b1, op, addr, sd, rd);
      @(negedge clk);
      drive(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0);
      for (int k = 1; k <= lat; k++) begin
         chk("wait_mem_en", {31'd0, dm_bus.mem_en}, 32'd1);
         chk("wait_ex_ready", {31'd0, ex_bus.ex_ready}, 32'd0);
         chk("wait_mem_addr", {16'd0, dm_bus.mem_addr}, {16'd0, exp_addr});
         chk("wait_mem_wr", {31'd0, dm_bus.mem_wr}, {31'd0, is_wr});
         if (is_wr) chk("wait_mem_wdata", {16'd0, dm_bus.mem_wdata}, {16'd0, sd});
         chk("wait_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd0);
         if (k == lat) begin
            dm_bus.mem_done  = 1'b1;
            dm_bus.mem_rdata = rdata;
         end else begin
            dm_bus.mem_done  = 1'b0;
            dm_bus.mem_rdata = 16'hDEAD;
         end
         @(negedge clk);
      end
      dm_bus.mem_done  = 1'b0;
      dm_bus.mem_rdata = 16'h0;
      chk("done_mem_en", {31'd0, dm_bus.mem_en}, 32'd0);
      chk("done_ex_ready", {31'd0, ex_bus.ex_ready}, 32'd1);
      chk("done_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd1);
      chk("done_wb_rd", {28'd0, wb_bus.wb_rd}, {28'd0, rd});
      chk("done_wb_we", {31'd0, wb_bus.wb_we}, {31'd0, ~is_wr});
      if (!is_wr) chk("done_wb_data", {16'd0, wb_bus.wb_data}, {16'd0, rdata});
      @(negedge clk);
      chk("after_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      vecs[0] = '{4'b0000, 16'h1234, 4'd3, 1'b1, 16'h1234};  // ADD
      vecs[1] = '{4'b0010, 16'h00FF, 4'd5, 1'b1, 16'h00FF};  // XOR
      vecs[2] = '{4'b0001, 16'hFFFF, 4'd1, 1'b1, 16'hFFFF};  // SUB
      vecs[3] = '{4'b0111, 16'h7F80, 4'd15, 1'b1, 16'h7F80}; // PADDSB
      vecs[4] = '{4'b1010, 16'hAB00, 4'd6, 1'b1, 16'hAB00};  // LHB
      vecs[5] = '{4'b1011, 16'h00CD, 4'd7, 1'b1, 16'h00CD};  // LLB
      vecs[6] = '{4'b1110, 16'h0042, 4'd14, 1'b1, 16'h0042}; // PCS
      vecs[7] = '{4'b1100, 16'h5555, 4'd9, 1'b0, 16'h0000};  // B
      vecs[8] = '{4'b1101, 16'h3333, 4'd10, 1'b0, 16'h0000}; // BR

      rst = 1'b1;
      drive(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0);
      dm_bus.mem_done  = 1'b0;
      dm_bus.mem_rdata = 16'h0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ex_ready", {31'd0, ex_bus.ex_ready}, 32'd1);
      chk("rst_mem_en", {31'd0, dm_bus.mem_en}, 32'd0);
      chk("rst_mem_wr", {31'd0, dm_bus.mem_wr}, 32'd0);
      chk("rst_mem_addr", {16'd0, dm_bus.mem_addr}, 32'd0);
      chk("rst_mem_wdata", {16'd0, dm_bus.mem_wdata}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd0);
      chk("rst_wb_we", {31'd0, wb_bus.wb_we}, 32'd0);
      chk("rst_wb_rd", {28'd0, wb_bus.wb_rd}, 32'd0);
      chk("rst_wb_data", {16'd0, wb_bus.wb_data}, 32'd0);
      chk("rst_align_err", {31'd0, align_err}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd0);

      // Back-to-back pass-through and branch ops, one record per cycle.
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, vecs[i].op, vecs[i].alu, 16'hFFFF, vecs[i].rd);
         @(negedge clk);
         chk("tbl_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd1);
         chk("tbl_wb_rd", {28'd0, wb_bus.wb_rd}, {28'd0, vecs[i].rd});
         chk("tbl_wb_we", {31'd0, wb_bus.wb_we}, {31'd0, vecs[i].we});
         chk("tbl_wb_data", {16'd0, wb_bus.wb_data}, {16'd0, vecs[i].data});
         chk("tbl_ex_ready", {31'd0, ex_bus.ex_ready}, 32'd1);
         chk("tbl_mem_en", {31'd0, dm_bus.mem_en}, 32'd0);
      end
      drive(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0);
      dm_bus.mem_done = 1'b1;
      @(negedge clk);
      dm_bus.mem_done = 1'b0;
      @(negedge clk);
      chk("stray_done_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd0);
      chk("stray_done_stall", {16'd0, stall_cycles}, 32'd0);
      chk("stray_done_mem_en", {31'd0, dm_bus.mem_en}, 32'd0);

      mem_op(4'b1000, 16'h0040, 16'h0000, 4'd4, 3, 16'hBEEF);
      chk("lw_stall", {16'd0, stall_cycles}, 32'd3);
      chk("lw_align_err", {31'd0, align_err}, 32'd0);

      mem_op(4'b1001, 16'h0101, 16'hA5A5, 4'd8, 1, 16'h0000);
      chk("sw_stall", {16'd0, stall_cycles}, 32'd4);
      chk("sw_align_err", {31'd0, align_err}, 32'd1);

      // Reset in the middle of an outstanding LW.
      drive(1'b1, 4'b1000, 16'h0080, 16'h0, 4'd2);
      @(negedge clk);
      drive(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0);
      chk("prerst_mem_en", {31'd0, dm_bus.mem_en}, 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_mem_en", {31'd0, dm_bus.mem_en}, 32'd0);
      chk("midrst_stall", {16'd0, stall_cycles}, 32'd0);
      chk("midrst_align_err", {31'd0, align_err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dm_bus.mem_done  = 1'b1;
      dm_bus.mem_rdata = 16'h1111;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("postrst_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd0);
         chk("postrst_mem_en", {31'd0, dm_bus.mem_en}, 32'd0);
         chk("postrst_ex_ready", {31'd0, ex_bus.ex_ready}, 32'd1);
      end
      dm_bus.mem_done = 1'b0;

      // HLT, then EX keeps offering an ADD.
      drive(1'b1, 4'b1111, 16'h4444, 16'h0, 4'd2);
      @(negedge clk);
      chk("hlt_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd1);
      chk("hlt_wb_we", {31'd0, wb_bus.wb_we}, 32'd0);
      chk("hlt_halted", {31'd0, halted}, 32'd1);
      chk("hlt_ex_ready", {31'd0, ex_bus.ex_ready}, 32'd0);
      drive(1'b1, 4'b0000, 16'h9999, 16'h0, 4'd1);
      for (int k = 0; k < 4; k++) begin
         dm_bus.mem_done = k[0];
         @(negedge clk);
         chk("halted_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd0);
         chk("halted_mem_en", {31'd0, dm_bus.mem_en}, 32'd0);
         chk("halted_ex_ready", {31'd0, ex_bus.ex_ready}, 32'd0);
         chk("halted_sticky", {31'd0, halted}, 32'd1);
      end
      dm_bus.mem_done = 1'b0;
      drive(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("unhalt_halted", {31'd0, halted}, 32'd0);
      chk("unhalt_ex_ready", {31'd0, ex_bus.ex_ready}, 32'd1);

      // Long LW: counter must stop at all-ones.
      drive(1'b1, 4'b1000, 16'h0200, 16'h0, 4'd7);
      @(negedge clk);
      drive(1'b0, 4'b0000, 16'h0, 16'h0, 4'd0);
      for (int k = 1; k <= 65538; k++) begin
         if (k == 65535) chk("sat_stall_fffe", {16'd0, stall_cycles}, 32'h0000FFFE);
         if (k == 65536) chk("sat_stall_ffff", {16'd0, stall_cycles}, 32'h0000FFFF);
         if (k == 65538) begin
            chk("sat_stall_hold", {16'd0, stall_cycles}, 32'h0000FFFF);
            chk("sat_mem_en", {31'd0, dm_bus.mem_en}, 32'd1);
            dm_bus.mem_done  = 1'b1;
            dm_bus.mem_rdata = 16'h1357;
         end
         @(negedge clk);
      end
      dm_bus.mem_done = 1'b0;
      chk("sat_wb_valid", {31'd0, wb_bus.wb_valid}, 32'd1);
      chk("sat_wb_data", {16'd0, wb_bus.wb_data}, 32'h00001357);
      chk("sat_wb_rd", {28'd0, wb_bus.wb_rd}, 32'd7);
      chk("sat_stall_final", {16'd0, stall_cycles}, 32'h0000FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
